uart_rx_core: RTL
=================

Name: uart_rx_core

Overview:
UART receiver: 8N1 serial input to a parallel byte, delivered over a valid/ready handshake. It is the receive-side counterpart of the team's UART transmit path and uses the same clk (50 MHz on DE10-Lite) and baud timing. It sits between the FPGA uart_rx pin and any byte consumer, such as a command decoder or loopback logic.

Parameters:
CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range >= 8
DATA_BITS, 8, data bits per frame; fixed at 8 for this revision

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
uart_rx  in  1  serial line; idle high; asynchronous to clk
rx_data  out  8  received byte; stable while rx_valid=1
rx_valid  out  1  byte available
rx_ready  in  1  consumer accepts byte when rx_valid&&rx_ready
frame_err  out  1  one-cycle pulse: stop bit sampled 0
overrun  out  1  one-cycle pulse: new byte dropped because buffer still full
rx_busy  out  1  high in START/DATA/STOP states

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun=0, rx_busy=0.
- Reset internals: state=WAIT_IDLE, bit counter=0, bit index=0, shift register=0.
- Synchronizer flops reset to 0, so the receiver arms only after the line is genuinely high.
- uart_rx passes through a 2-flop synchronizer (rxs). All decisions use rxs. Pin-to-rxs latency is 2 cycles.
- Baud counter width is $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 - 1 (integer division).
- State WAIT_IDLE: when rxs=1, go to IDLE.
- State IDLE: when rxs=0, counter=0 and go to START.
- State START: count to HALF, then sample.
  - rxs=0: counter=0, bit index=0, go to DATA.
  - rxs=1: treat as a glitch, go to IDLE; no outputs change.
- State DATA: count to CLKS_PER_BIT-1, then sample rxs into the shift register, LSB first.
  - Bit index increments on each sample.
  - After the 8th sample, counter=0 and go to STOP.
- State STOP: count to CLKS_PER_BIT-1, then sample.
  - rxs=1 and buffer free, or rxs=1 with rx_valid&&rx_ready in the same cycle: next edge rx_data=shift, rx_valid=1. Go to IDLE (mid-stop-bit, so back-to-back frames are supported).
  - rxs=1, rx_valid=1 and rx_ready=0: overrun=1 for one cycle. New byte discarded; rx_data and rx_valid unchanged. Go to IDLE.
  - rxs=0: frame_err=1 for one cycle, byte discarded, go to WAIT_IDLE (covers break conditions).
- Handshake:
  - rx_valid stays high until a cycle with rx_valid&&rx_ready; it clears on the next edge.
  - rx_data must not change while rx_valid=1.
  - If a consume and a new load coincide, the load wins: rx_valid stays 1 and rx_data takes the new byte.
- Latency: rx_valid rises 1 cycle after the mid-stop-bit sample, about 2 + 9.5*CLKS_PER_BIT cycles after the start-bit falling edge on the pin.
- frame_err and overrun are never asserted together. Both are 0 outside their single pulse cycle.
- Reset mid-frame: partial byte lost, outputs return to reset values immediately (asynchronous). Reception restarts after the line is seen high.
  - A high data bit may re-arm the receiver mid-frame; resulting misframes are reported via frame_err.

Decomposition:
- Package uart_pkg:
  - rx state enum: WAIT_IDLE, IDLE, START, DATA, STOP
  - DEFAULT_CLKS_PER_BIT=434
  - DATA_BITS=8
- Sub-module uart_rx_sync: 2-flop synchronizer with reset value 0, reusable for other async inputs.

Test Plan:
(All scenarios use CLKS_PER_BIT=16.)
1. Line high 50 cycles, then frame 0x55, rx_ready=1 -> rx_valid high exactly 1 cycle with rx_data=0x55; frame_err=0, overrun=0.
2. Frame 0xA3, rx_ready=0 for 200 cycles -> rx_valid stays 1 and rx_data=0xA3 throughout. Raise rx_ready -> rx_valid=0 on the next edge.
3. Low glitch of 4 cycles (< HALF=7), then frame 0x0F -> no output for the glitch; exactly one rx_valid with 0x0F.
4. Frame 0x7E with stop bit=0 -> frame_err 1-cycle pulse, no rx_valid. Hold line low 100 cycles, release, send 0x81 -> rx_data=0x81.
5. Back-to-back 0x11, 0x22 with rx_ready=0 -> rx_data=0x11 held; overrun pulse at 0x22's stop sample. After ready, rx_data still 0x11 on the consume cycle.
6. Assert rst_n=0 during data bit 4 of a frame -> all outputs 0 at once. Release with line high, send 0xC4 -> rx_valid with rx_data=0xC4.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, default baud divisor and frame width.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;
    localparam int DATA_BITS            = 8;

    typedef enum logic [2:0] {
        WAIT_IDLE,
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input; 2-cycle latency, no backpressure.
// Resets to 0 so downstream logic never mistakes reset for an idle-high line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = din;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver to a one-entry valid/ready byte buffer; rx_valid ~2+9.5*CLKS_PER_BIT cycles after start edge.
// A byte arriving while the buffer is still full is dropped and flagged with an overrun pulse.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 rx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

    logic rxs;

    rx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_rx_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (uart_rx),
        .dout  (rxs)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q && !rx_ready;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        case (state_q)
            WAIT_IDLE: begin
                if (rxs) state_d = IDLE;
            end
            IDLE: begin
                if (!rxs) begin
                    cnt_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                // Re-check the start bit at its midpoint to reject short glitches.
                if (cnt_q == HALF) begin
                    if (!rxs) begin
                        cnt_d     = '0;
                        bit_idx_d = '0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d     = '0;
                    shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + IW'(1);
                    if (bit_idx_q == LAST_BIT) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == FULL) begin
                    cnt_d = '0;
                    if (!rxs) begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_IDLE;
                    end else begin
                        // Return to IDLE mid-stop-bit so a back-to-back start edge is caught.
                        state_d = IDLE;
                        if (!rx_valid_q || rx_ready) begin
                            rx_data_d  = shift_q;
                            rx_valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = WAIT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= WAIT_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign rx_busy   = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule
